// File: rtl/dm_param.sv
// dm_param: byte/half/word data memory with registered, extended load data and a post-reset
// hardware clear. Defining DM_ALIGN_CHECK_EN rejects misaligned/reserved accesses with an err pulse.
module dm_param #(
    parameter int ADDR_W         = 12,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       din,
    input  logic              memwrite,
    input  logic              memread,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    output logic              ready,
    output logic [31:0]       dout,
    output logic              dout_valid,
    output logic              err
);
    localparam int              WA       = ADDR_W - 2;
    localparam int              DEPTH    = 2 ** WA;
    localparam logic [WA-1:0]   LAST_IDX = WA'(DEPTH - 1);
    localparam logic [0:0]      ST_CLEAR = 1'b0;
    localparam logic [0:0]      ST_IDLE  = 1'b1;
    localparam logic [1:0]      SZ_BYTE  = 2'b00;
    localparam logic [1:0]      SZ_HALF  = 2'b01;
    localparam logic [1:0]      SZ_WORD  = 2'b10;

    logic [0:0]    state_q, state_d;
    logic [WA-1:0] clr_ptr_q, clr_ptr_d;
    logic          clearing, accept, misalign, wr_en, rd_en;
    logic [1:0]    size_eff;
    logic [WA-1:0] ram_idx;
    logic [31:0]   ram_rdata;
    logic          rd_pend_q, rd_pend_d;
    logic [1:0]    ld_size_q, ld_size_d;
    logic [1:0]    ld_off_q, ld_off_d;
    logic          ld_sext_q, ld_sext_d;
    logic [31:0]   dout_q, dout_d, ld_ext;
    logic          dout_valid_q, dout_valid_d;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;

    assign clearing = (state_q == ST_CLEAR);
    assign ready    = ~clearing;
    assign accept   = ready & (memwrite | memread);
    // Reserved size behaves as a word when alignment checking is off.
    assign size_eff = (size == 2'b11) ? SZ_WORD : size;
    assign wr_en    = accept & memwrite & ~misalign;
    assign rd_en    = accept & memread & ~misalign;
    assign ram_idx  = clearing ? clr_ptr_q : addr[ADDR_W-1:2];

`ifdef DM_ALIGN_CHECK_EN
    logic err_pend_q, err_pend_d, err_q, err_d;

    always_comb begin
        misalign = 1'b0;
        case (size)
            2'b01:   misalign = addr[0];
            2'b10:   misalign = (addr[1:0] != 2'b00);
            2'b11:   misalign = 1'b1;
            default: misalign = 1'b0;
        endcase
    end

    assign err_pend_d = accept & misalign;
    assign err_d      = err_pend_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pend_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_pend_q <= err_pend_d;
            err_q      <= err_d;
        end
    end

    assign err = err_q;
`else
    assign misalign = 1'b0;
    assign err      = 1'b0;
`endif

    // One single-port, read-before-write byte lane per generate iteration.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        logic [7:0] mem [DEPTH];
        logic [7:0] rdata_q;
        logic       we;
        logic [7:0] wdata;

        always_comb begin
            we    = 1'b0;
            wdata = 8'h00;
            if (clearing) begin
                we = 1'b1;
            end else if (wr_en) begin
                case (size_eff)
                    SZ_BYTE: begin
                        we    = (addr[1:0] == LANE);
                        wdata = din[7:0];
                    end
                    SZ_HALF: begin
                        we    = (addr[1] == LANE[1]);
                        wdata = LANE[0] ? din[15:8] : din[7:0];
                    end
                    default: begin
                        we    = 1'b1;
                        wdata = din[8*gi +: 8];
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (we) begin
                mem[ram_idx] <= wdata;
            end
            if (rd_en) begin
                rdata_q <= mem[ram_idx];
            end
        end

        assign ram_rdata[8*gi +: 8] = rdata_q;
    end

    always_comb begin
        ld_byte = ram_rdata[{ld_off_q, 3'b000} +: 8];
        ld_half = ld_off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (ld_size_q)
            SZ_BYTE: ld_ext = {{24{ld_sext_q & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_ext = {{16{ld_sext_q & ld_half[15]}}, ld_half};
            default: ld_ext = ram_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (clearing) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == LAST_IDX) begin
                state_d = ST_IDLE;
            end
        end
        rd_pend_d    = rd_en;
        ld_size_d    = rd_en ? size_eff : ld_size_q;
        ld_off_d     = rd_en ? addr[1:0] : ld_off_q;
        ld_sext_d    = rd_en ? sign_ext : ld_sext_q;
        dout_d       = rd_pend_q ? ld_ext : dout_q;
        dout_valid_d = rd_pend_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clr_ptr_q    <= '0;
            rd_pend_q    <= 1'b0;
            ld_size_q    <= SZ_WORD;
            ld_off_q     <= 2'b00;
            ld_sext_q    <= 1'b0;
            dout_q       <= 32'h0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            rd_pend_q    <= rd_pend_d;
            ld_size_q    <= ld_size_d;
            ld_off_q     <= ld_off_d;
            ld_sext_q    <= ld_sext_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_dm_param.sv
// Self-checking bench for dm_param: expected load data is queued at issue time and
// compared against the dout_valid stream captured one sample after each rising edge.
module tb_dm_param;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 2 ** (ADDR_W - 2);

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b1;
    logic [ADDR_W-1:0] addr     = '0;
    logic [31:0]       din      = '0;
    logic              memwrite = 1'b0;
    logic              memread  = 1'b0;
    logic [1:0]        size     = 2'b10;
    logic              sign_ext = 1'b0;
    logic              ready;
    logic [31:0]       dout;
    logic              dout_valid;
    logic              err;

    int n_checks     = 0;
    int n_pass       = 0;
    int cyc          = 0;
    int err_cnt      = 0;
    int last_err_cyc = -1;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    dm_param #(.ADDR_W(ADDR_W), .CLEAR_ON_RESET(1)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .din(din), .memwrite(memwrite),
        .memread(memread), .size(size), .sign_ext(sign_ext), .ready(ready),
        .dout(dout), .dout_valid(dout_valid), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (dout_valid) got_q.push_back(dout);
        if (err) begin
            err_cnt++;
            last_err_cyc = cyc;
        end
    endtask

    task automatic idle();
        memwrite = 1'b0;
        memread  = 1'b0;
    endtask

    task automatic store(input logic [11:0] a, input logic [31:0] d, input logic [1:0] sz);
        addr = a; din = d; size = sz; memwrite = 1'b1; memread = 1'b0;
        tick();
        idle();
    endtask

    task automatic load(input logic [11:0] a, input logic [1:0] sz, input logic sx, input logic [31:0] e);
        addr = a; size = sz; sign_ext = sx; memread = 1'b1; memwrite = 1'b0;
        exp_q.push_back(e);
        tick();
        idle();
    endtask

    task automatic settle();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        int n;
        logic [31:0] e, g;
        repeat (3) tick();
        n_checks++; if (ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", ready); else n_pass++;
        n_checks++; if (dout !== 32'h0) $display("FAIL rst_dout: got %h want 0", dout); else n_pass++;
        n_checks++; if (dout_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", dout_valid); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else n_pass++;
        rst_n = 1'b1;
        n = 0;
        while (!ready && n < 3000) begin
            if (n == 600) begin
                addr = 12'h0F0; din = 32'h12345678; size = 2'b10; memwrite = 1'b1; memread = 1'b1;
            end else begin
                idle();
            end
            tick();
            n++;
        end
        idle();
        n_checks++; if (n != DEPTH) $display("FAIL clear_len: ready after %0d edges want %0d", n, DEPTH); else n_pass++;
        n_checks++; if (got_q.size() != 0) $display("FAIL clear_drop: %0d outputs during clear want 0", got_q.size()); else n_pass++;
        got_q.delete();
        load(12'hFFC, 2'b10, 1'b0, 32'h0);
        load(12'h000, 2'b10, 1'b0, 32'h0);
        load(12'h0F0, 2'b10, 1'b0, 32'h0);
        settle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) $display("FAIL reset_load: no output want %h", e);
            else begin g = got_q.pop_front(); if (g !== e) $display("FAIL reset_load: got %h want %h", g, e); else n_pass++; end
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] e, g;
        store(12'h010, 32'h11223344, 2'b10);
        store(12'h012, 32'h123456A5, 2'b00);
        load(12'h010, 2'b10, 1'b0, 32'h11A53344);
        load(12'h012, 2'b00, 1'b1, 32'hFFFFFFA5);
        load(12'h012, 2'b00, 1'b0, 32'h000000A5);
        load(12'h013, 2'b00, 1'b1, 32'h00000011);
        load(12'h010, 2'b00, 1'b1, 32'h00000044);
        load(12'h012, 2'b01, 1'b1, 32'h000011A5);
        load(12'h010, 2'b01, 1'b0, 32'h00003344);
        settle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) $display("FAIL byte_load: no output want %h", e);
            else begin g = got_q.pop_front(); if (g !== e) $display("FAIL byte_load: got %h want %h", g, e); else n_pass++; end
        end
        n_checks++; if (got_q.size() != 0) $display("FAIL byte_extra: %0d extra outputs want 0", got_q.size()); else n_pass++;
        got_q.delete();
    endtask

    task automatic test_half();
        logic [31:0] e, g;
        store(12'h022, 32'hABCD8001, 2'b01);
        load(12'h020, 2'b10, 1'b0, 32'h80010000);
        load(12'h022, 2'b01, 1'b1, 32'hFFFF8001);
        load(12'h022, 2'b01, 1'b0, 32'h00008001);
        load(12'h020, 2'b01, 1'b1, 32'h00000000);
        load(12'h023, 2'b00, 1'b1, 32'hFFFFFF80);
        settle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) $display("FAIL half_load: no output want %h", e);
            else begin g = got_q.pop_front(); if (g !== e) $display("FAIL half_load: got %h want %h", g, e); else n_pass++; end
        end
    endtask

    task automatic test_read_write();
        logic [31:0] e, g;
        store(12'h030, 32'h00000000, 2'b10);
        addr = 12'h030; din = 32'hDEADBEEF; size = 2'b10; memwrite = 1'b1; memread = 1'b1;
        exp_q.push_back(32'h00000000);
        tick();
        idle();
        load(12'h030, 2'b10, 1'b0, 32'hDEADBEEF);
        settle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) $display("FAIL rw_same: no output want %h", e);
            else begin g = got_q.pop_front(); if (g !== e) $display("FAIL rw_same: got %h want %h", g, e); else n_pass++; end
        end
        n_checks++; if (got_q.size() != 0) $display("FAIL rw_extra: %0d extra outputs want 0", got_q.size()); else n_pass++;
        got_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [8];
        logic [31:0] e, g;
        for (int i = 0; i < 8; i++) begin
            words[i] = $urandom | 32'h01010101;
            store(12'h100 + 12'(i * 4), words[i], 2'b10);
            load(12'h100 + 12'(i * 4), 2'b10, 1'b0, words[i]);
        end
        for (int i = 0; i < 8; i++) load(12'h100 + 12'(i * 4), 2'b10, 1'b0, words[i]);
        for (int b = 0; b < 4; b++) load(12'h11C + 12'(b), 2'b00, 1'b0, {24'h0, words[7][8*b +: 8]});
        settle();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) $display("FAIL b2b_load: no output want %h", e);
            else begin g = got_q.pop_front(); if (g !== e) $display("FAIL b2b_load: got %h want %h", g, e); else n_pass++; end
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        int bad;
        logic [31:0] e;
        rst_n = 1'b0;
        #2;
        n_checks++; if (dout !== 32'h0) $display("FAIL mid_rst_dout: got %h want 0", dout); else n_pass++;
        n_checks++; if (ready !== 1'b0) $display("FAIL mid_rst_ready: got %b want 0", ready); else n_pass++;
        tick();
        rst_n = 1'b1;
        repeat (500) tick();
        n_checks++; if (ready !== 1'b0) $display("FAIL mid_clear_ready: got %b want 0", ready); else n_pass++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n = 0;
        while (!ready && n < 3000) begin
            tick();
            n++;
        end
        n_checks++; if (n != DEPTH) $display("FAIL restart_len: ready after %0d edges want %0d", n, DEPTH); else n_pass++;
        got_q.delete();
        for (int i = 0; i < DEPTH; i++) load(12'(i * 4), 2'b10, 1'b0, 32'h0);
        settle();
        bad = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() == 0) bad++;
            else if (got_q.pop_front() !== e) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL clear_all: %0d bad words want 0", bad); else n_pass++;
    endtask

    task automatic test_misalign();
        int c0;
        logic [31:0] e, g;
        got_q.delete();
        err_cnt = 0;
        store(12'h041, 32'hCAFEF00D, 2'b10);
        c0 = cyc;
        settle();
`ifdef DM_ALIGN_CHECK_EN
        n_checks++; if (err_cnt != 1 || last_err_cyc != c0 + 1) $display("FAIL mis_err: %0d pulses at %0d want 1 at %0d", err_cnt, last_err_cyc, c0 + 1); else n_pass++;
        load(12'h040, 2'b10, 1'b0, 32'h00000000);
        store(12'h044, 32'h0BADCAFE, 2'b11);
        load(12'h044, 2'b10, 1'b0, 32'h00000000);
        addr = 12'h051; size = 2'b01; sign_ext = 1'b0; memread = 1'b1;
        tick();
        idle();
        settle();
        n_checks++; if (err_cnt != 3) $display("FAIL mis_err_cnt: got %0d want 3", err_cnt); else n_pass++;
`else
        n_checks++; if (err_cnt != 0) $display("FAIL mis_err: got %0d pulses want 0 (c0 %0d)", err_cnt, c0); else n_pass++;
        load(12'h040, 2'b10, 1'b0, 32'hCAFEF00D);
        store(12'h044, 32'h0BADCAFE, 2'b11);
        load(12'h044, 2'b10, 1'b0, 32'h0BADCAFE);
        load(12'h051, 2'b01, 1'b0, 32'h00000000);
        settle();
        n_checks++; if (err_cnt != 0) $display("FAIL mis_err_cnt: got %0d want 0", err_cnt); else n_pass++;
`endif
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) $display("FAIL mis_load: no output want %h", e);
            else begin g = got_q.pop_front(); if (g !== e) $display("FAIL mis_load: got %h want %h", g, e); else n_pass++; end
        end
        n_checks++; if (got_q.size() != 0) $display("FAIL mis_extra: %0d extra outputs want 0", got_q.size()); else n_pass++;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        test_reset();
        test_byte_lanes();
        test_half();
        test_read_write();
        test_back_to_back();
        test_reset_mid_clear();
        test_misalign();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dm_param.md
# dm_param

Parametrised data memory for the CPU datapath, the successor to the fixed 4 KB word-only data memory. It supports byte, halfword and word loads and stores with optional sign extension. Read data is registered with a valid strobe, and the array is cleared in hardware after reset. It sits between the ALU address output and the write-back mux, and a `ready` output stalls the pipeline while the clear sequence runs.

## Interface
Parameters:
- `ADDR_W`, 12: byte-address width. Depth is `DEPTH = 2**(ADDR_W-2)` 32-bit words. Legal range is 4 to 20.
- `CLEAR_ON_RESET`, 1: when 1, the array is zeroed after reset. When 0, the block comes up ready immediately with contents undefined.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `addr`  in  ADDR_W  byte address; `addr[ADDR_W-1:2]` is the word index and `addr[1:0]` is the byte offset.
- `din`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `memwrite`  in  1  store request.
- `memread`  in  1  load request.
- `size`  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- `sign_ext`  in  1  loads only: 1 sign-extends byte/half results, 0 zero-extends them.
- `ready`  out  1  block accepts requests this cycle.
- `dout`  out  32  load result, extended to 32 bits.
- `dout_valid`  out  1  one-cycle pulse; `dout` holds a new load result.
- `err`  out  1  one-cycle pulse; misaligned or reserved-size access rejected.

## Operation
- **FSM states.**
  - CLEAR: `ready`=0. The block writes 0 to `mem[clr_ptr]` and increments `clr_ptr` each cycle. When `clr_ptr`=DEPTH-1 it moves to IDLE.
  - IDLE: `ready`=1.
  - Reset enters CLEAR with `clr_ptr`=0, or IDLE directly if `CLEAR_ON_RESET`=0.
- **Acceptance.** A request is accepted when `ready`=1 and (`memwrite` or `memread`) is high. Requests made while `ready`=0 are dropped, not queued. The pipeline must hold them.
- **Store lanes.**
  - Byte: `din[7:0]` goes to lane `addr[1:0]`.
  - Half: `din[15:0]` goes to lanes {`addr[1]`,0} and {`addr[1]`,1}.
  - Word: all four lanes.
  - Lanes that are not enabled keep their old contents.
- **Load extract.**
  - Byte: the selected lane.
  - Half: the selected lane pair.
  - Word: the full word.
  - Byte and half results are extended to 32 bits per `sign_ext`.
- **Simultaneous read and write** to the same address: both are performed. `dout` returns the pre-write contents (read-before-write).
- **Word-index wrap.** There is none; every `ADDR_W` address maps to a unique word.
- **Output hold.** `dout` keeps its last value when `dout_valid`=0.

## Timing
- **Reset values.** `ready`=0 (1 if `CLEAR_ON_RESET`=0), `dout`=0, `dout_valid`=0, `err`=0, `clr_ptr`=0.
- **Clear duration.** The first `ready`=1 occurs exactly DEPTH cycles after the first rising edge with `rst_n`=1. Example: 1024 cycles at the default `ADDR_W`.
- **Reset during CLEAR** aborts the clear. It restarts from `clr_ptr`=0 after release.
- **Store latency.** A store is visible to a load accepted on the next cycle.
- **Load latency.** A load accepted at edge N produces `dout`/`dout_valid`=1 after edge N+1, for exactly one cycle.
- **Throughput.** One request per cycle, with back-to-back loads and stores supported.
- **Error latency.** `err`, when enabled, pulses in the same cycle position as `dout_valid` would have.

## Configuration
- **`DM_ALIGN_CHECK_EN` defined.** These accesses are rejected:
  - half with `addr[0]`=1;
  - word with `addr[1:0]`≠0;
  - any `size`=11.
  - For a rejected access: no array write, `dout` unchanged, `dout_valid`=0, and `err` pulses one cycle after acceptance.
- **Not defined.** `err` is tied to 0. Offset bits below the access size are ignored:
  - half uses `addr[1]` only;
  - word ignores `addr[1:0]`;
  - `size`=11 is treated as a word.

## Test plan
- **Reset clear:** `CLEAR_ON_RESET`=1, `ADDR_W`=12. Release reset → `ready` rises at cycle 1024. A word load from 0x0FFC → `dout`=0x00000000.
- **Byte stores and signed/unsigned byte loads:**
  - Store word 0x11223344 at 0x010, then store byte 0xA5 at 0x012.
  - Word load → 0x11A53344.
  - Byte load from 0x012 with `sign_ext`=1 → 0xFFFFFFA5; with `sign_ext`=0 → 0x000000A5.
- **Halfword store and signed load:** store half 0x8001 at 0x022 → word at 0x020 becomes 0x8001xxxx. Half load with `sign_ext`=1 → 0xFFFF8001.
- **Simultaneous load and store:**
  - Word 0x00000000 at 0x030; `memread` and `memwrite` together with 0xDEADBEEF.
  - `dout`=0x00000000; the next load returns 0xDEADBEEF.
- **Misalignment with `DM_ALIGN_CHECK_EN`:**
  - Word store at 0x041 → `err` pulses, memory unchanged.
  - Without the macro, the same store writes word 0x040 and `err` stays 0.
- **Reset mid-clear:** assert `rst_n`=0 at clear cycle 500. Release → `ready` rises 1024 cycles later and all locations read 0.
